// File: rtl/id_ex_pipe_reg_pkg.sv
// mips_pipe_pkg: definitions shared by the MIPS32 pipeline boundary registers.
//   - default field widths (DATA_W, REG_W, CTRL_W)
//   - bit positions of each control signal inside the control bundle
//   - ALUOp encodings
//   - state encoding for the 2-entry skid register
//   - packed ID/EX payload struct (default widths)
package mips_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 11;

    // Control bundle, MSB first:
    // {Jump, MemToReg, RegWrite, ALUSrc, MemWrite, ALUOp[2:0], MemRead, Branch, RegDst}
    localparam int CTRL_REGDST   = 0;
    localparam int CTRL_BRANCH   = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_ALUOP_LO = 3;
    localparam int CTRL_ALUOP_HI = 5;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMTOREG = 9;
    localparam int CTRL_JUMP     = 10;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rsData;
        logic [DATA_W-1:0] rtData;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] jtarget;
        logic [REG_W-1:0]  rtAddr;
        logic [REG_W-1:0]  rdAddr;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_payload_t;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: ID -> EX boundary signals.
//   in_*      : ID-side valid/ready handshake and payload
//   flush     : synchronous bubble insert
//   out_*     : EX-side valid/ready handshake and registered payload
// Modports:
//   slave  : the pipeline register (consumes in_*, produces out_*)
//   master : the surrounding pipeline (drives in_*, flush, out_ready)
interface id_ex_pipe_reg_if #(
    parameter int DATA_W = mips_pipe_pkg::DATA_W,
    parameter int REG_W  = mips_pipe_pkg::REG_W,
    parameter int CTRL_W = mips_pipe_pkg::CTRL_W
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pc4;
    logic [DATA_W-1:0] in_rs_data;
    logic [DATA_W-1:0] in_rt_data;
    logic [DATA_W-1:0] in_imm;
    logic [DATA_W-1:0] in_jtarget;
    logic [REG_W-1:0]  in_rt_addr;
    logic [REG_W-1:0]  in_rd_addr;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_pc4;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_jtarget;
    logic [REG_W-1:0]  out_rt_addr;
    logic [REG_W-1:0]  out_rd_addr;
    logic [CTRL_W-1:0] out_ctrl;

    modport slave (
        input  in_valid, in_pc4, in_rs_data, in_rt_data, in_imm, in_jtarget,
               in_rt_addr, in_rd_addr, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_pc4, out_rs_data, out_rt_data, out_imm,
               out_jtarget, out_rt_addr, out_rd_addr, out_ctrl
    );

    modport master (
        output in_valid, in_pc4, in_rs_data, in_rt_data, in_imm, in_jtarget,
               in_rt_addr, in_rd_addr, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_pc4, out_rs_data, out_rt_data, out_imm,
               out_jtarget, out_rt_addr, out_rd_addr, out_ctrl
    );
endinterface

// File: rtl/id_ex_pipe_reg_skid_buf.sv
// pipe_skid_buf: generic 2-entry skid register with synchronous flush.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : drop both entries (priority over accept and pop)
//   inValid/inReady     : upstream handshake, inData payload
//   outValid/outReady   : downstream handshake, outData payload (main entry)
//
// state       | meaning
// ------------+-------------------------------------------
// SKID_EMPTY  | no entry valid
// SKID_ONE    | main entry valid, skid entry free
// SKID_FULL   | main and skid valid, upstream held off
module pipe_skid_buf
    import mips_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData
);
    skid_state_t      state;
    skid_state_t      stateNext;
    logic [WIDTH-1:0] mainData;
    logic [WIDTH-1:0] skidData;
    logic             accept;
    logic             pop;
    logic             loadMain;
    logic             loadSkid;
    logic             moveSkid;

    // Both flags come straight from state, so in_ready never sees out_ready.
    assign inReady  = (state != SKID_FULL);
    assign outValid = (state != SKID_EMPTY);
    assign accept   = inValid && inReady;
    assign pop      = outValid && outReady;
    assign outData  = mainData;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SKID_EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (flush) begin
            stateNext = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: if (accept) stateNext = SKID_ONE;
                SKID_ONE: begin
                    if (pop && !accept)      stateNext = SKID_EMPTY;
                    else if (accept && !pop) stateNext = SKID_FULL;
                end
                SKID_FULL:  if (pop) stateNext = SKID_ONE;
                default:    stateNext = SKID_EMPTY;
            endcase
        end
    end

    always_comb begin
        loadMain = 1'b0;
        loadSkid = 1'b0;
        moveSkid = 1'b0;
        if (!flush) begin
            case (state)
                SKID_EMPTY: loadMain = accept;
                SKID_ONE: begin
                    loadMain = accept && pop;
                    loadSkid = accept && !pop;
                end
                SKID_FULL:  moveSkid = pop;
                default: ;
            endcase
        end
    end

    // Flush clears the stored words so no stale control survives a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainData <= '0;
            skidData <= '0;
        end else if (flush) begin
            mainData <= '0;
            skidData <= '0;
        end else begin
            if (loadMain)      mainData <= inData;
            else if (moveSkid) mainData <= skidData;
            if (loadSkid)      skidData <= inData;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline boundary register for the MIPS32 core.
// Carries PC+4, operands, immediate, jump target, RT/RD addresses and the
// control bundle from decode into execute through a 2-entry skid register.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus (slave)   : in_* / out_* handshakes and payload, flush
//   stall_cycles  : (only with STALL_CNT_EN) saturating count of cycles
//                   with out_valid && !out_ready; reset clears, flush does not
// Build option: define STALL_CNT_EN to add the stall counter.
module id_ex_pipe_reg #(
    parameter int DATA_W = mips_pipe_pkg::DATA_W,
    parameter int REG_W  = mips_pipe_pkg::REG_W,
    parameter int CTRL_W = mips_pipe_pkg::CTRL_W
) (
    input  logic clk,
    input  logic rst_n,
    id_ex_pipe_reg_if.slave bus
`ifdef STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);
    import mips_pipe_pkg::*;

    localparam int PAY_W = 5 * DATA_W + 2 * REG_W + CTRL_W;

    logic [PAY_W-1:0]  inPayload;
    logic [PAY_W-1:0]  outPayload;
    logic [CTRL_W-1:0] storedCtrl;

    assign inPayload = {bus.in_pc4, bus.in_rs_data, bus.in_rt_data, bus.in_imm,
                        bus.in_jtarget, bus.in_rt_addr, bus.in_rd_addr, bus.in_ctrl};

    pipe_skid_buf #(.WIDTH(PAY_W)) skidBuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.flush),
        .inValid  (bus.in_valid),
        .inReady  (bus.in_ready),
        .inData   (inPayload),
        .outValid (bus.out_valid),
        .outReady (bus.out_ready),
        .outData  (outPayload)
    );

    assign {bus.out_pc4, bus.out_rs_data, bus.out_rt_data, bus.out_imm,
            bus.out_jtarget, bus.out_rt_addr, bus.out_rd_addr, storedCtrl} = outPayload;

    // A bubble must never carry live control into EX.
    assign bus.out_ctrl = bus.out_valid ? storedCtrl : '0;

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (bus.out_valid && !bus.out_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
